// File: rtl/sid_bus_pkg.sv
// Shared definitions for the SID register-bus writer: register map,
// pin layout, request format and bus-sequencer states.
package sid_bus_pkg;

  // Implemented register addresses; 3 and 7 are reserved on the chip
  localparam logic [2:0] FREQ_LO  = 3'd0;
  localparam logic [2:0] FREQ_HI  = 3'd1;
  localparam logic [2:0] PW       = 3'd2;
  localparam logic [2:0] ATTACK   = 3'd4;
  localparam logic [2:0] SUSTAIN  = 3'd5;
  localparam logic [2:0] WAVEFORM = 3'd6;

  // Bit positions inside pin_ui
  localparam int ADDR_LSB  = 0;
  localparam int VOICE_BIT = 3;
  localparam int WE_BIT    = 7;

  // One queued register write (12 bits)
  typedef struct packed {
    logic       voice;
    logic [2:0] addr;
    logic [7:0] data;
  } sid_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_GAP
  } sid_state_e;

  // Addresses 3 and 7 have no register behind them
  function automatic logic is_reserved(input logic [2:0] addr);
    return (addr == 3'd3) || (addr == 3'd7);
  endfunction

endpackage

// File: rtl/sid_req_fifo.sv
// Request FIFO: synchronous, no fall-through. An entry written at one edge
// is visible on rdata only from the following cycle.
module sid_req_fifo
  import sid_bus_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  sid_req_t      wdata,
  input  logic          pop,
  output sid_req_t      rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  sid_req_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy update; pointers wrap since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; occupancy guards every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sid_reg_writer.sv
// Host-side SID register-bus master. Buffers write requests and replays
// each one as setup / strobe / gap so we gets exactly one clean pulse.
module sid_reg_writer
  import sid_bus_pkg::*;
#(
  parameter  int DEPTH      = 4,
  parameter  int SETUP_CYC  = 2,
  parameter  int STROBE_CYC = 2,
  parameter  int GAP_CYC    = 2,
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_voice,
  input  logic [2:0]    in_addr,
  input  logic [7:0]    in_data,
  output logic          err_addr,
  output logic          busy,
  output logic [LW-1:0] level,
  output logic [7:0]    pin_ui,
  output logic [7:0]    pin_uio
);

  // Phase counter only ever holds (phase length - 1)
  localparam int MAX_SG  = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int MAX_CYC = (STROBE_CYC > MAX_SG) ? STROBE_CYC : MAX_SG;
  localparam int CW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

  sid_req_t      in_req, fifo_rdata;
  sid_req_t      req_q, req_d;
  sid_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic          accept, reserved, push, pop, load;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;

  sid_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_req),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Intake: ready depends only on occupancy, reserved addresses are dropped
  always_comb begin
    in_req   = '{voice: in_voice, addr: in_addr, data: in_data};
    reserved = is_reserved(in_addr);
    accept   = in_valid && !fifo_full;
    push     = accept && !reserved;
    err_d    = accept && reserved;
  end

  // Bus sequencer: next state, phase counter, we and the pin latch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    req_d   = req_q;
    pop     = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        we_d = 1'b0;
        load = !fifo_empty;
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = CW'(STROBE_CYC - 1);
          we_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = CW'(GAP_CYC - 1);
          we_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          // Chain straight into the next write when one is queued
          load    = !fifo_empty;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        we_d    = 1'b0;
      end
    endcase
    if (load) begin
      pop     = 1'b1;
      req_d   = fifo_rdata;
      state_d = ST_SETUP;
      cnt_d   = CW'(SETUP_CYC - 1);
    end
  end

  // Sequencer and output registers; reset aborts any write in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  // Pin mapping: everything comes straight from flops, so pins are glitch-free
  always_comb begin
    pin_ui                    = '0;
    pin_ui[ADDR_LSB +: 3]     = req_q.addr;
    pin_ui[VOICE_BIT]         = req_q.voice;
    pin_ui[WE_BIT]            = we_q;
    pin_uio                   = req_q.data;
  end

  assign in_ready = !fifo_full;
  assign err_addr = err_q;
  assign level    = fifo_level;
  assign busy     = (fifo_level != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_sid_reg_writer.sv
// Bench for sid_reg_writer: a default-timing instance (a) and a
// SETUP=1/STROBE=3/GAP=1 instance (b), each shadowed by a timer-based model.
module tb_sid_reg_writer;
  import sid_bus_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, a_voice, b_valid, b_voice;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       a_ready, a_err, a_busy, b_ready, b_err, b_busy;
  logic [2:0] a_level, b_level;
  logic [7:0] a_ui, a_uio, b_ui, b_uio;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  sid_reg_writer #(.DEPTH(DEPTH), .SETUP_CYC(2), .STROBE_CYC(2), .GAP_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_voice(a_voice),
    .in_addr(a_addr), .in_data(a_data), .err_addr(a_err), .busy(a_busy),
    .level(a_level), .pin_ui(a_ui), .pin_uio(a_uio));

  sid_reg_writer #(.DEPTH(DEPTH), .SETUP_CYC(1), .STROBE_CYC(3), .GAP_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_voice(b_voice),
    .in_addr(b_addr), .in_data(b_data), .err_addr(b_err), .busy(b_busy),
    .level(b_level), .pin_ui(b_ui), .pin_uio(b_uio));

  // ---------------- reference model ----------------
  // A write popped at edge p drives its pins from p, raises we at p+S,
  // drops it at p+S+P, and the next pop may happen at p+S+P+G or later.
  int          cfg_s[2] = '{2, 1};
  int          cfg_p[2] = '{2, 3};
  int          cfg_g[2] = '{2, 1};
  int          t = 0;
  int          m_hd[2], m_tl[2], m_next[2], m_rise[2], m_fall[2];
  logic [11:0] m_mem[2][64];
  logic [11:0] m_pins[2];
  logic        m_err[2];
  logic        rst_edge = 1'b1;

  function automatic int lvl(input int d);
    return m_tl[d] - m_hd[d];
  endfunction

  task automatic model_step(input int d, input logic r, input logic v, input logic vo,
                            input logic [2:0] ad, input logic [7:0] dt);
    logic acc, res, pop;
    if (r) begin
      m_hd[d] = 0; m_tl[d] = 0; m_next[d] = 0; m_rise[d] = 0; m_fall[d] = 0;
      m_pins[d] = '0; m_err[d] = 1'b0;
    end else begin
      acc = v && (lvl(d) < DEPTH);
      res = (ad == 3'd3) || (ad == 3'd7);
      m_err[d] = acc && res;
      pop = (lvl(d) > 0) && (t >= m_next[d]);
      if (pop) begin
        m_pins[d] = m_mem[d][m_hd[d] % 64];
        m_hd[d]++;
        m_rise[d] = t + cfg_s[d];
        m_fall[d] = m_rise[d] + cfg_p[d];
        m_next[d] = m_fall[d] + cfg_g[d];
      end
      if (acc && !res) begin
        m_mem[d][m_tl[d] % 64] = {vo, ad, dt};
        m_tl[d]++;
      end
    end
  endtask

  always @(posedge clk) begin
    t++;
    rst_edge <= rst;
    model_step(0, rst, a_valid, a_voice, a_addr, a_data);
    model_step(1, rst, b_valid, b_voice, b_addr, b_data);
  end

  // ---------------- receiver / monitor ----------------
  logic [11:0] rx_a[$], rx_b[$];
  int          rise_a[$], rise_b[$], fall_b[$];
  int          viol_a = 0, viol_b = 0, max_lvl_a = 0, max_lvl_b = 0;
  logic        pa_we = 1'b0, pb_we = 1'b0;
  logic [11:0] pa_pins = '0, pb_pins = '0;
  logic [21:0] mon_act, mon_exp;
  logic        mon_we;
  int          mon_lv;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        mon_lv  = lvl(d);
        mon_we  = (t >= m_rise[d]) && (t < m_fall[d]);
        mon_act = (d == 0) ? {a_ready, a_err, a_busy, a_level, a_ui, a_uio}
                           : {b_ready, b_err, b_busy, b_level, b_ui, b_uio};
        mon_exp = {mon_lv < DEPTH, m_err[d], (mon_lv != 0) || (t < m_next[d]), 3'(mon_lv),
                   mon_we, 3'b000, m_pins[d][11:8], m_pins[d][7:0]};
        n_checks++;
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL model_cmp dut%0d cycle %0d: got %h want %h (ready,err,busy,level,ui,uio)",
                   d, t, mon_act, mon_exp);
        end
      end
    end
    // receiver latches on each we rising edge; pins must not move around a strobe
    if (a_ui[7] && !pa_we) begin rx_a.push_back({a_ui[3:0], a_uio}); rise_a.push_back(t); end
    if (b_ui[7] && !pb_we) begin rx_b.push_back({b_ui[3:0], b_uio}); rise_b.push_back(t); end
    if (!b_ui[7] && pb_we && !rst_edge) fall_b.push_back(t);
    if (!rst_edge && (a_ui[7] || pa_we) && ({a_ui[3:0], a_uio} != pa_pins)) viol_a++;
    if (!rst_edge && (b_ui[7] || pb_we) && ({b_ui[3:0], b_uio} != pb_pins)) viol_b++;
    if (int'(a_level) > max_lvl_a) max_lvl_a = int'(a_level);
    if (int'(b_level) > max_lvl_b) max_lvl_b = int'(b_level);
    pa_we = a_ui[7]; pa_pins = {a_ui[3:0], a_uio};
    pb_we = b_ui[7]; pb_pins = {b_ui[3:0], b_uio};
  end

  // ---------------- scenarios ----------------
  task automatic wait_idle(input int maxc);
    int c = 0;
    do begin @(negedge clk); c++; end while ((a_busy || b_busy) && c < maxc);
    n_checks++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy a=%b b=%b after %0d cycles, want 0", a_busy, b_busy, maxc);
    end
  endtask

  function automatic logic [2:0] rand_ok_addr();
    logic [2:0] tbl[6] = '{FREQ_LO, FREQ_HI, PW, ATTACK, SUSTAIN, WAVEFORM};
    return tbl[$urandom_range(0, 5)];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a_ui, a_uio, a_level, a_busy, a_err, a_ready} !== {8'h0, 8'h0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_a: got ui=%h uio=%h level=%0d busy=%b err=%b ready=%b, want 0/0/0/0/0/1",
               a_ui, a_uio, a_level, a_busy, a_err, a_ready);
    end
    n_checks++;
    if ({b_ui, b_uio, b_level, b_busy, b_err, b_ready} !== {8'h0, 8'h0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_b: got ui=%h uio=%h level=%0d busy=%b err=%b ready=%b, want 0/0/0/0/0/1",
               b_ui, b_uio, b_level, b_busy, b_err, b_ready);
    end
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] eui;
    logic       eb;
    @(negedge clk); a_valid = 1'b1; a_voice = 1'b0; a_addr = FREQ_HI; a_data = 8'h5A;
    @(negedge clk); a_valid = 1'b0;           // accepted at the edge just passed
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      eui = (n == 3 || n == 4) ? 8'h81 : 8'h01;
      eb  = (n <= 6);
      n_checks++;
      if (a_ui !== eui || a_uio !== 8'h5A || a_busy !== eb) begin
        n_fail++;
        $display("FAIL single k+%0d: got ui=%h uio=%h busy=%b, want ui=%h uio=5a busy=%b",
                 n, a_ui, a_uio, a_busy, eui, eb);
      end
    end
  endtask

  task automatic test_burst();
    logic [2:0]  ba[4] = '{FREQ_LO, FREQ_HI, ATTACK, WAVEFORM};
    logic [7:0]  bd[4] = '{8'h11, 8'h22, 8'h33, 8'h41};
    logic [11:0] got;
    rx_a.delete(); rise_a.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); a_valid = 1'b1; a_voice = 1'b1; a_addr = ba[i]; a_data = bd[i];
    end
    @(negedge clk); a_valid = 1'b0;
    wait_idle(100);
    n_checks++;
    if (rx_a.size() != 4) begin
      n_fail++; $display("FAIL burst_count: got %0d writes, want 4", rx_a.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < rx_a.size()) ? rx_a[i] : 12'hxxx;
      n_checks++;
      if (got !== {1'b1, ba[i], bd[i]}) begin
        n_fail++; $display("FAIL burst_data[%0d]: got %h want %h", i, got, {1'b1, ba[i], bd[i]});
      end
    end
    for (int i = 0; i + 1 < rise_a.size(); i++) begin
      n_checks++;
      if (rise_a[i+1] - rise_a[i] != 6) begin
        n_fail++; $display("FAIL burst_spacing[%0d]: got %0d want 6", i, rise_a[i+1] - rise_a[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [11:0] exp_q[$];
    logic [11:0] e, got;
    logic        acc;
    rx_a.delete(); max_lvl_a = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = {1'($urandom_range(0, 1)), rand_ok_addr(), 8'($urandom)};
      acc = (lvl(0) < DEPTH);
      n_checks++;
      if (a_ready !== acc) begin
        n_fail++; $display("FAIL overflow_ready[%0d]: got %b want %b", i, a_ready, acc);
      end
      if (acc) exp_q.push_back(e);
      a_valid = 1'b1; {a_voice, a_addr, a_data} = e;
    end
    @(negedge clk); a_valid = 1'b0;
    wait_idle(200);
    n_checks++;
    if (rx_a.size() != 5) begin
      n_fail++; $display("FAIL overflow_count: got %0d writes, want 5", rx_a.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rx_a.size()) ? rx_a[i] : 12'hxxx;
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++; $display("FAIL overflow_data[%0d]: got %h want %h", i, got, exp_q[i]);
      end
    end
    n_checks++;
    if (max_lvl_a != DEPTH) begin
      n_fail++; $display("FAIL overflow_maxlevel: got %0d want %0d", max_lvl_a, DEPTH);
    end
  endtask

  task automatic test_reserved();
    logic [2:0] ra[2] = '{3'd3, 3'd7};
    rise_a.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); a_valid = 1'b1; a_voice = 1'($urandom_range(0, 1)); a_addr = ra[i]; a_data = 8'($urandom);
      @(negedge clk); a_valid = 1'b0;
      n_checks++;
      if (a_err !== 1'b1 || a_level !== 3'd0) begin
        n_fail++; $display("FAIL reserved_pulse[%0d]: got err=%b level=%0d, want err=1 level=0", i, a_err, a_level);
      end
      @(negedge clk);
      n_checks++;
      if (a_err !== 1'b0) begin
        n_fail++; $display("FAIL reserved_clear[%0d]: got err=%b want 0", i, a_err);
      end
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (rise_a.size() != 0 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL reserved_nowrite: got %0d we edges busy=%b, want 0 edges busy=0", rise_a.size(), a_busy);
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); a_valid = 1'b1; a_voice = 1'b0; a_addr = rand_ok_addr(); a_data = 8'($urandom);
    end
    @(negedge clk); a_valid = 1'b0;
    while (a_ui[7] !== 1'b1 && c < 20) begin @(negedge clk); c++; end
    n_checks++;
    if (a_ui[7] !== 1'b1 || a_level !== 3'd2) begin
      n_fail++; $display("FAIL resetmid_pre: got we=%b level=%0d, want we=1 level=2", a_ui[7], a_level);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_ui !== 8'h00 || a_uio !== 8'h00 || a_level !== 3'd0) begin
      n_fail++; $display("FAIL resetmid_post: got ui=%h uio=%h level=%0d, want 0/0/0", a_ui, a_uio, a_level);
    end
    rst = 1'b0;
    rise_a.delete();
    repeat (30) @(negedge clk);
    n_checks++;
    if (rise_a.size() != 0 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL resetmid_quiet: got %0d we edges busy=%b, want 0 edges busy=0", rise_a.size(), a_busy);
    end
  endtask

  task automatic test_timing();
    logic [11:0] exp_q[$];
    logic [11:0] e, got;
    rx_b.delete(); rise_b.delete(); fall_b.delete(); viol_b = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = {1'($urandom_range(0, 1)), rand_ok_addr(), 8'($urandom)};
      exp_q.push_back(e);
      b_valid = 1'b1; {b_voice, b_addr, b_data} = e;
    end
    @(negedge clk); b_valid = 1'b0;
    wait_idle(100);
    n_checks++;
    if (rx_b.size() != 4 || fall_b.size() != 4) begin
      n_fail++; $display("FAIL timing_count: got %0d rises %0d falls, want 4/4", rx_b.size(), fall_b.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < rx_b.size()) ? rx_b[i] : 12'hxxx;
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++; $display("FAIL timing_data[%0d]: got %h want %h", i, got, exp_q[i]);
      end
    end
    for (int i = 0; i < rise_b.size() && i < fall_b.size(); i++) begin
      n_checks++;
      if (fall_b[i] - rise_b[i] != 3) begin
        n_fail++; $display("FAIL timing_high[%0d]: got %0d cycles want 3", i, fall_b[i] - rise_b[i]);
      end
    end
    for (int i = 0; i + 1 < rise_b.size(); i++) begin
      n_checks++;
      if (rise_b[i+1] - rise_b[i] != 5) begin
        n_fail++; $display("FAIL timing_spacing[%0d]: got %0d want 5", i, rise_b[i+1] - rise_b[i]);
      end
    end
    n_checks++;
    if (viol_b != 0) begin
      n_fail++; $display("FAIL timing_stable: got %0d pin changes around we, want 0", viol_b);
    end
  endtask

  task automatic test_random();
    viol_a = 0; viol_b = 0; max_lvl_a = 0; max_lvl_b = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      a_valid = 1'($urandom_range(0, 1)); a_voice = 1'($urandom_range(0, 1));
      a_addr  = 3'($urandom_range(0, 7)); a_data  = 8'($urandom);
      b_valid = 1'($urandom_range(0, 1)); b_voice = 1'($urandom_range(0, 1));
      b_addr  = 3'($urandom_range(0, 7)); b_data  = 8'($urandom);
    end
    @(negedge clk); a_valid = 1'b0; b_valid = 1'b0;
    wait_idle(400);
    n_checks++;
    if (viol_a != 0 || viol_b != 0 || max_lvl_a > DEPTH || max_lvl_b > DEPTH) begin
      n_fail++;
      $display("FAIL random_invariants: got viol a=%0d b=%0d maxlvl a=%0d b=%0d, want 0/0/<=4/<=4",
               viol_a, viol_b, max_lvl_a, max_lvl_b);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_voice = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_voice = 1'b0; b_addr = '0; b_data = '0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_reserved();
    test_reset_mid();
    test_timing();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
